// File: rtl/alu_scheduler_if.sv
// Client-side bundle of the ALU scheduler:
// two request ports and the tagged result handshake.
interface alu_scheduler_if;
  logic       req0;
  logic       req1;
  logic [3:0] a0;
  logic [3:0] b0;
  logic [2:0] s0;
  logic [3:0] a1;
  logic [3:0] b1;
  logic [2:0] s1;
  logic       gnt0;
  logic       gnt1;
  logic [7:0] res;
  logic       res_id;
  logic       res_valid;
  logic       res_ready;

  modport master (
    output req0, req1,
    output a0, b0, s0,
    output a1, b1, s1,
    output res_ready,
    input  gnt0, gnt1,
    input  res, res_id, res_valid
  );

  modport slave (
    input  req0, req1,
    input  a0, b0, s0,
    input  a1, b1, s1,
    input  res_ready,
    output gnt0, gnt1,
    output res, res_id, res_valid
  );
endinterface

// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one external 4-bit ALU
// between two clients; result returned over valid/ready.
module alu_scheduler #(
  parameter int unsigned LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  alu_scheduler_if.slave cl,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic [2:0]   alu_s,
  input  logic [7:0]   alu_y,
  output logic         busy,
  output logic [7:0]   ops_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [3:0] LAT_C  = 4'(LAT);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic [2:0] alu_s_q, alu_s_d;
  logic [7:0] res_q, res_d;
  logic       res_id_q, res_id_d;
  logic       res_valid_q, res_valid_d;
  logic [7:0] ops_q, ops_d;
  logic       g0, g1;

  // last_q=1 hands a tie to client 0
  assign g0 = cl.req0 & (~cl.req1 | last_q);
  assign g1 = cl.req1 & ~g0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_s_d     = alu_s_q;
    res_d       = res_q;
    res_id_d    = res_id_q;
    res_valid_d = res_valid_q;
    ops_d       = ops_q;
    unique case (state_q)
      S_IDLE: begin
        if (g0 | g1) begin
          gnt0_d   = g0;
          gnt1_d   = g1;
          alu_a_d  = g1 ? cl.a1 : cl.a0;
          alu_b_d  = g1 ? cl.b1 : cl.b0;
          alu_s_d  = g1 ? cl.s1 : cl.s0;
          res_id_d = g1;
          cnt_d    = LAT_C;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          res_d       = alu_y;
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (res_valid_q & cl.res_ready) begin
          res_valid_d = 1'b0;
          ops_d       = ops_q + 8'd1;
          last_d      = res_id_q;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      last_q      <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      alu_a_q     <= 4'd0;
      alu_b_q     <= 4'd0;
      alu_s_q     <= 3'd0;
      res_q       <= 8'd0;
      res_id_q    <= 1'b0;
      res_valid_q <= 1'b0;
      ops_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_s_q     <= alu_s_d;
      res_q       <= res_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
      ops_q       <= ops_d;
    end
  end

  assign cl.gnt0      = gnt0_q;
  assign cl.gnt1      = gnt1_q;
  assign cl.res       = res_q;
  assign cl.res_id    = res_id_q;
  assign cl.res_valid = res_valid_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_s        = alu_s_q;
  assign busy         = (state_q != S_IDLE);
  assign ops_done     = ops_q;

endmodule
